fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage RISC-V core: owns the PC register, the next-PC select, the instruction-memory request handshake and the IF/ID pipeline register. It sits directly upstream of the ID-stage control unit. It consumes that unit's `pcSel`, `pcStall` and `ifidStall`, and produces the `dpc`/`dinst` it decodes. It tolerates variable-latency instruction memory and squashes wrong-path fetches on redirect.

---
 rtl/fetch_stage_pkg.sv | 33 +++
 rtl/fetch_stage_ifid.sv | 30 +++
 rtl/fetch_stage.sv | 135 +++++++++++++
 tb/tb_fetch_stage.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: next-PC select codes, bubble instruction,
// IF FSM state codes and the IF/ID payload layout.
package fetch_stage_pkg;

  localparam logic [1:0]  PCSEL_PC4    = 2'b00;
  localparam logic [1:0]  PCSEL_BR     = 2'b01;
  localparam logic [1:0]  PCSEL_JMP    = 2'b10;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    IF_FETCH = 2'd0,
    IF_HOLD  = 2'd1,
    IF_DROP  = 2'd2
  } if_state_e;

  // 97-bit IF/ID payload
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic        valid;
  } ifid_t;

  function automatic ifid_t ifid_bubble(input logic [31:0] nop);
    ifid_t b;
    b.pc    = 32'h0;
    b.pc4   = 32'h0;
    b.inst  = nop;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_stage_ifid.sv
// IF/ID pipeline register; a bubble request overrides a load in the same cycle.
module ifid_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic  clk,
  input  logic  clrn,
  input  logic  load,
  input  logic  bubble,
  input  ifid_t din,
  output ifid_t dout
);

  ifid_t ifid_q, ifid_d;

  always_comb begin
    ifid_d = ifid_q;
    if (bubble)    ifid_d = ifid_bubble(NOP_INST);
    else if (load) ifid_d = din;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) ifid_q <= ifid_bubble(NOP_INST);
    else       ifid_q <= ifid_d;
  end

  assign dout = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, next-PC select, single-outstanding imem
// handshake with wrong-path squash, and the IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [1:0]  pcSel,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic        pcStall,
  input  logic        ifidStall,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemRdata,
  output logic [31:0] dpc,
  output logic [31:0] dpc4,
  output logic [31:0] dinst,
  output logic        dvalid,
  output logic        fetchBusy
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic [31:0] drop_addr_q, drop_addr_d;

  logic        redirect, stall;
  logic [31:0] target, pc_plus4;
  logic        ifid_load, ifid_bub;
  ifid_t       ifid_in, ifid_out;

  assign redirect = (pcSel == PCSEL_BR) || (pcSel == PCSEL_JMP);
  assign target   = (pcSel == PCSEL_BR) ? bpc : jpc;
  assign stall    = pcStall | ifidStall;
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_inst_d   = hold_inst_q;
    drop_addr_d   = drop_addr_q;
    ifid_load     = 1'b0;
    ifid_bub      = 1'b0;
    ifid_in.pc    = pc_q;
    ifid_in.pc4   = pc_plus4;
    ifid_in.inst  = imemRdata;
    ifid_in.valid = 1'b1;
    imemReq       = 1'b0;
    imemAddr      = pc_q;

    case (state_q)
      IF_FETCH: begin
        imemReq = 1'b1;
        if (imemAck) begin
          if (redirect) begin
            pc_d     = target;
            ifid_bub = 1'b1;
          end else if (stall) begin
            hold_inst_d = imemRdata;
            state_d     = IF_HOLD;
          end else begin
            ifid_load = 1'b1;
            pc_d      = pc_plus4;
          end
        end else if (redirect) begin
          // the in-flight request must still complete at its original address
          drop_addr_d = pc_q;
          pc_d        = target;
          ifid_bub    = 1'b1;
          state_d     = IF_DROP;
        end else if (!stall) begin
          ifid_bub = 1'b1;
        end
      end

      IF_HOLD: begin
        ifid_in.inst = hold_inst_q;
        if (redirect) begin
          pc_d     = target;
          ifid_bub = 1'b1;
          state_d  = IF_FETCH;
        end else if (!stall) begin
          ifid_load = 1'b1;
          pc_d      = pc_plus4;
          state_d   = IF_FETCH;
        end
      end

      IF_DROP: begin
        imemReq  = 1'b1;
        imemAddr = drop_addr_q;
        if (redirect) pc_d = target;
        if (redirect || !stall) ifid_bub = 1'b1;
        if (imemAck) state_d = IF_FETCH;
      end

      default: state_d = IF_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= IF_FETCH;
      pc_q        <= RESET_PC;
      hold_inst_q <= 32'h0;
      drop_addr_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      hold_inst_q <= hold_inst_d;
      drop_addr_q <= drop_addr_d;
    end
  end

  ifid_reg #(.NOP_INST(NOP_INST)) u_ifid (
    .clk    (clk),
    .clrn   (clrn),
    .load   (ifid_load),
    .bubble (ifid_bub),
    .din    (ifid_in),
    .dout   (ifid_out)
  );

  assign dpc       = ifid_out.pc;
  assign dpc4      = ifid_out.pc4;
  assign dinst     = ifid_out.inst;
  assign dvalid    = ifid_out.valid;
  assign fetchBusy = imemReq & ~imemAck;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage: a variable-latency memory,
// random redirects/stalls, and a program-order model of what must reach ID.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk, clrn;
  logic [1:0]  pcSel;
  logic [31:0] bpc, jpc;
  logic        pcStall, ifidStall;
  logic        imemReq, imemAck, fetchBusy, dvalid;
  logic [31:0] imemAddr, imemRdata, dpc, dpc4, dinst;

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk(clk), .clrn(clrn), .pcSel(pcSel), .bpc(bpc), .jpc(jpc),
    .pcStall(pcStall), .ifidStall(ifidStall),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemRdata(imemRdata),
    .dpc(dpc), .dpc4(dpc4), .dinst(dinst), .dvalid(dvalid), .fetchBusy(fetchBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  // instruction memory: each request acks after a random number of wait cycles
  int min_lat = 0, max_lat = 0;
  int cnt, lat;
  assign imemAck   = imemReq && (cnt >= lat);
  assign imemRdata = imemAck ? memf(imemAddr) : 32'hDEAD_BEEF;

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt <= 0;
      lat <= 0;
    end else if (imemReq && imemAck) begin
      cnt <= 0;
      lat <= int'($urandom_range(max_lat, min_lat));
    end else if (imemReq) begin
      cnt <= cnt + 1;
    end
  end

  typedef struct {
    logic        redir;
    logic        stall;
    logic [31:0] target;
  } item_t;

  typedef struct {
    logic        req, ack, dvalid;
    logic [31:0] addr, dpc, dpc4, dinst;
  } snap_t;

  item_t       q[$];
  bit          mon_en = 1'b0;
  logic [31:0] exp_pc;
  int          n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_bubble(input string nm);
    chk({nm, "_dvalid"}, {31'h0, dvalid}, 32'h0);
    chk({nm, "_dinst"}, dinst, NOP);
    chk({nm, "_dpc"}, dpc, 32'h0);
    chk({nm, "_dpc4"}, dpc4, 32'h0);
  endtask

  task automatic step(input logic [1:0] sel, input logic [31:0] b, input logic [31:0] j,
                      input logic ps, input logic is);
    item_t it;
    pcSel = sel; bpc = b; jpc = j; pcStall = ps; ifidStall = is;
    it.redir  = (sel == 2'b01) || (sel == 2'b10);
    it.stall  = ps | is;
    it.target = (sel == 2'b01) ? b : j;
    if (mon_en) q.push_back(it);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_tgt();
    if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
    return 32'(4 * $urandom_range(0, 255));
  endfunction

  task automatic rand_step();
    int r;
    logic [1:0] sel;
    r = int'($urandom_range(0, 99));
    sel = (r < 8) ? 2'b01 : (r < 16) ? 2'b10 : (r < 19) ? 2'b11 : 2'b00;
    step(sel, rand_tgt(), rand_tgt(), $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 8);
  endtask

  // monitor: each item describes the inputs of one edge; judge the outputs after it
  initial begin
    item_t pend;
    snap_t prv, cur;
    bit    have;
    int    idle;
    have = 1'b0;
    idle = 0;
    forever begin
      @(negedge clk);
      cur.req = imemReq; cur.ack = imemAck; cur.addr = imemAddr;
      cur.dpc = dpc; cur.dpc4 = dpc4; cur.dinst = dinst; cur.dvalid = dvalid;
      if (!mon_en) begin
        have = 1'b0;
        idle = 0;
      end else begin
        if (have) begin
          chk("fetch_busy", {31'h0, fetchBusy}, {31'h0, imemReq & ~imemAck});
          if (prv.req && !prv.ack) begin
            chk("pending_req_held", {31'h0, cur.req}, 32'h1);
            chk("pending_addr_stable", cur.addr, prv.addr);
          end
          if (pend.redir) begin
            chk_bubble("redirect_bubble");
            exp_pc = pend.target;
            if (prv.ack || !prv.req) begin
              chk("redirect_req", {31'h0, cur.req}, 32'h1);
              chk("redirect_addr", cur.addr, pend.target);
            end
          end else if (pend.stall) begin
            chk("stall_dpc", cur.dpc, prv.dpc);
            chk("stall_dinst", cur.dinst, prv.dinst);
            chk("stall_dvalid", {31'h0, cur.dvalid}, {31'h0, prv.dvalid});
          end else if (cur.dvalid) begin
            chk("deliver_dpc", cur.dpc, exp_pc);
            chk("deliver_dpc4", cur.dpc4, exp_pc + 32'd4);
            chk("deliver_dinst", cur.dinst, memf(exp_pc));
            exp_pc = exp_pc + 32'd4;
            idle = 0;
          end else begin
            chk_bubble("advance_bubble");
            idle++;
            if (idle > 16) begin
              n_tests++;
              n_fail++;
              $display("FAIL progress: %0d bubbles without delivery, expected at most 16", idle);
              idle = 0;
            end
          end
        end
        if (q.size() > 0) begin
          pend = q.pop_front();
          prv  = cur;
          have = 1'b1;
        end else begin
          have = 1'b0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pending;
    clrn = 1'b0; pcSel = 2'b00; bpc = 32'h0; jpc = 32'h0; pcStall = 1'b0; ifidStall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {31'h0, imemReq}, 32'h1);
    chk("rst_addr", imemAddr, RST_PC);
    chk("rst_busy", {31'h0, fetchBusy}, 32'h0);
    chk_bubble("rst");

    // zero-wait memory: one instruction per cycle, wrapping past 0xFFFF_FFFC
    exp_pc = RST_PC;
    clrn   = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("zw_addr", imemAddr, RST_PC + 32'(4 * i));
      if (i > 0) begin
        chk("zw_dvalid", {31'h0, dvalid}, 32'h1);
        chk("zw_dinst", dinst, memf(RST_PC + 32'(4 * (i - 1))));
      end
      step(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    end

    max_lat = 3;
    for (int c = 0; c < 3000; c++) rand_step();

    // async reset in the middle of a pending request
    min_lat = 2;
    mon_en  = 1'b0;
    q.delete();
    pending = 1'b0;
    for (int c = 0; c < 40 && !pending; c++) begin
      step(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
      pending = imemReq && !imemAck;
    end
    chk("pending_seen", {31'h0, pending}, 32'h1);
    #2 clrn = 1'b0;
    #1;
    chk("async_rst_req", {31'h0, imemReq}, 32'h1);
    chk("async_rst_addr", imemAddr, RST_PC);
    chk_bubble("async_rst");
    @(posedge clk); #1;
    min_lat = 0;
    exp_pc  = RST_PC;
    clrn    = 1'b1;
    mon_en  = 1'b1;
    for (int c = 0; c < 200; c++) rand_step();
    step(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
